// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states and long-op classification.
package alu_pkg;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00010;
    localparam logic [4:0] OP_SLL   = 5'b00100;
    localparam logic [4:0] OP_SLT   = 5'b00110;
    localparam logic [4:0] OP_SLTU  = 5'b00111;
    localparam logic [4:0] OP_MUL   = 5'b01000;
    localparam logic [4:0] OP_MULH  = 5'b01001;
    localparam logic [4:0] OP_MULHU = 5'b01011;
    localparam logic [4:0] OP_DIV   = 5'b01100;
    localparam logic [4:0] OP_DIVU  = 5'b01101;
    localparam logic [4:0] OP_REM   = 5'b01110;
    localparam logic [4:0] OP_REMU  = 5'b01111;
    localparam logic [4:0] OP_XOR   = 5'b10000;
    localparam logic [4:0] OP_SRL   = 5'b10100;
    localparam logic [4:0] OP_SRA   = 5'b10110;
    localparam logic [4:0] OP_OR    = 5'b11000;
    localparam logic [4:0] OP_AND   = 5'b11100;
    localparam logic [4:0] OP_LUI   = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_long_op(input logic [4:0] op);
        case (op)
            OP_MUL, OP_MULH, OP_MULHU,
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative radix-2 mul/div: shared hi/lo registers used as shift-add product or restoring
// remainder/quotient, with sign fix-up applied on the final iteration.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [4:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] res_o
);
    localparam int CW = $clog2(WIDTH);

    logic             busy_q, neg_q, bz_q;
    logic [CW-1:0]    cnt_q;
    logic [4:0]       op_q;
    logic [WIDTH-1:0] hi_q, lo_q, dvs_q;
    logic [WIDTH-1:0] hi_d, lo_d;

    logic             signed_op, sa, sb;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   sum, t, diff;
    logic [2*WIDTH-1:0] prod, prod_n;

    assign signed_op = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    assign sa        = signed_op & a_i[WIDTH-1];
    assign sb        = signed_op & b_i[WIDTH-1];
    assign a_mag     = sa ? -a_i : a_i;
    assign b_mag     = sb ? -b_i : b_i;

    // op_q[2] separates the divide group (011xx) from the multiply group (010xx)
    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
        t    = {hi_q, lo_q[WIDTH-1]};
        diff = t - {1'b0, dvs_q};
        if (op_q[2]) begin
            hi_d = diff[WIDTH] ? t[WIDTH-1:0] : diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign prod   = {hi_d, lo_d};
    assign prod_n = neg_q ? -prod : prod;
    assign done_o = busy_q && (cnt_q == CW'(WIDTH-1));

    always_comb begin
        res_o = '0;
        case (op_q)
            OP_MUL:           res_o = lo_d;
            OP_MULH:          res_o = prod_n[2*WIDTH-1:WIDTH];
            OP_MULHU:         res_o = hi_d;
            OP_DIV, OP_DIVU:  res_o = bz_q ? '1 : (neg_q ? -lo_d : lo_d);
            OP_REM, OP_REMU:  res_o = neg_q ? -hi_d : hi_d;
            default:          res_o = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            dvs_q  <= '0;
            neg_q  <= 1'b0;
            bz_q   <= 1'b0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            op_q   <= op_i;
            hi_q   <= '0;
            lo_q   <= a_mag;
            dvs_q  <= b_mag;
            // remainder takes the dividend's sign; product/quotient take the xor
            neg_q  <= (op_i == OP_REM) ? sa : (sa ^ sb);
            bz_q   <= (b_i == '0);
        end else if (busy_q) begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            cnt_q  <= cnt_q + 1'b1;
            if (done_o) busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle RV32I/M ALU with valid/ready handshake and registered result/zero.
// Define ALU_MULDIV_EN to build the iterative mul/div unit; otherwise long op codes yield 0.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    localparam int SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, short_res, md_res;
    logic             zero_q, zero_d;
    logic             accept, xfer, long_op, md_done;
    logic [SHW-1:0]   shamt;

    assign out_valid = (state_q == ST_DONE);
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign result    = result_q;
    assign zero      = zero_q;
    assign shamt     = rd2[SHW-1:0];

`ifdef ALU_MULDIV_EN
    assign long_op = is_long_op(op);

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (accept && long_op),
        .op_i    (op),
        .a_i     (rd1),
        .b_i     (rd2),
        .done_o  (md_done),
        .res_o   (md_res)
    );
`else
    assign long_op = 1'b0;
    assign md_done = 1'b0;
    assign md_res  = '0;
`endif

    always_comb begin
        short_res = '0;
        case (op)
            OP_ADD:  short_res = rd1 + rd2;
            OP_SUB:  short_res = rd1 - rd2;
            OP_AND:  short_res = rd1 & rd2;
            OP_OR:   short_res = rd1 | rd2;
            OP_XOR:  short_res = rd1 ^ rd2;
            OP_SLL:  short_res = rd1 << shamt;
            OP_SRL:  short_res = rd1 >> shamt;
            OP_SRA:  short_res = WIDTH'($signed(rd1) >>> shamt);
            OP_LUI:  short_res = rd1 + rd2;
            OP_SLT:  short_res = WIDTH'($signed(rd1) < $signed(rd2));
            OP_SLTU: short_res = WIDTH'(rd1 < rd2);
            default: short_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d = long_op ? ST_BUSY : ST_DONE;
                    if (!long_op) begin
                        result_d = short_res;
                        zero_d   = (short_res == '0);
                    end
                end else if (xfer) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (md_done) begin
                    state_d  = ST_DONE;
                    result_d = md_res;
                    zero_d   = (md_res == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

endmodule
